user_dac_loader: RTL and testbench

Downstream consumer of a JTAG user write register's parallel output (PO) in the CLK25 domain. Captures a configuration word and shifts it MSB-first to an external serial device, such as a comparator threshold DAC, over a 3-wire SCLK/SDATA/CS_N link. Provides BUSY/DONE status so a JTAG read register or local control logic can track completion.

---
 rtl/user_dac_loader.sv | 148 ++++++++++++++
 tb/tb_user_dac_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/user_dac_loader.sv
// Shifts a captured word MSB-first over SCLK/SDATA/CS_N with BUSY/DONE status.
// Optional USER_DAC_LOADER_AUTOLOAD_EN: a changed DIN also requests a frame.
module user_dac_loader #(
  parameter int               WIDTH     = 16,
  parameter int               CLK_DIV   = 2,
  parameter logic [WIDTH-1:0] DEF_VALUE = '0
) (
  input  logic             CLK25,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             SCLK,
  output logic             SDATA,
  output logic             CS_N,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] LAST
);

  localparam int MX = (CLK_DIV > WIDTH) ? CLK_DIV : WIDTH;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] CNT_H    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LO,
    S_HI,
    S_HOLD
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    bit_q;
  logic [WIDTH-1:0] shd_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] last_q;
  logic             sclk_q;
  logic             sdata_q;
  logic             cs_n_q;
  logic             busy_q;
  logic             done_q;
  logic             pend_q;
  logic             auto_d;
  logic             req_d;
  logic             start_d;

`ifdef USER_DAC_LOADER_AUTOLOAD_EN
  // shd_q equals LAST when idle and the in-flight word when busy
  assign auto_d = (DIN != shd_q);
`else
  assign auto_d = 1'b0;
`endif

  assign req_d   = LOAD | auto_d;
  assign start_d = req_d | pend_q;

  always_ff @(posedge CLK25) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shd_q   <= DEF_VALUE;
      sh_q    <= '0;
      last_q  <= DEF_VALUE;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && req_d)
        pend_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start_d) begin
            shd_q   <= DIN;
            sh_q    <= DIN << 1;
            sdata_q <= DIN[WIDTH-1];
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
            cnt_q   <= CNT_H;
            bit_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            cnt_q   <= CNT_H;
            state_q <= S_LO;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_LO: begin
          if (cnt_q == '0) begin
            sclk_q  <= 1'b1;
            cnt_q   <= CNT_H;
            state_q <= S_HI;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HI: begin
          if (cnt_q == '0) begin
            sclk_q <= 1'b0;
            cnt_q  <= CNT_H;
            if (bit_q == LAST_BIT) begin
              state_q <= S_HOLD;
            end else begin
              bit_q   <= bit_q + CW'(1);
              sdata_q <= sh_q[WIDTH-1];
              sh_q    <= sh_q << 1;
              state_q <= S_LO;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            last_q  <= shd_q;
            sdata_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign SCLK  = sclk_q;
  assign SDATA = sdata_q;
  assign CS_N  = cs_n_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign LAST  = last_q;

endmodule

// File: tb/tb_user_dac_loader.sv
// Scoreboard bench for user_dac_loader: frame-level model vs serial monitor.
// Honours USER_DAC_LOADER_AUTOLOAD_EN in the reference model.
module tb_user_dac_loader;

  localparam int          W     = 16;
  localparam int          H     = 2;
  localparam logic [W-1:0] DEF  = 16'h0000;
  localparam int          FRAME = 2 * H * (W + 1);

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] din;
  logic         sclk, sdata, cs_n, busy, done;
  logic [W-1:0] last;

  int n_tests = 0;
  int n_fail  = 0;

  user_dac_loader #(
    .WIDTH(W), .CLK_DIV(H), .DEF_VALUE(DEF)
  ) dut (
    .CLK25(clk), .RST_N(rst_n), .DIN(din), .LOAD(load),
    .SCLK(sclk), .SDATA(sdata), .CS_N(cs_n),
    .BUSY(busy), .DONE(done), .LAST(last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a fixed-length busy window.
  logic [W-1:0] exp_q[$];
  int           m_rem  = 0;
  bit           m_pend = 0;
  bit           m_done = 0;
  logic [W-1:0] m_last = DEF;
  logic [W-1:0] m_shd  = DEF;

  initial begin
    forever begin
      bit           l, r, au;
      logic [W-1:0] d;
      @(posedge clk);
      l = load; d = din; r = rst_n;
`ifdef USER_DAC_LOADER_AUTOLOAD_EN
      au = (d != m_shd);
`else
      au = 1'b0;
`endif
      m_done = 0;
      if (!r) begin
        if (m_rem != 0) void'(exp_q.pop_back());
        m_rem = 0; m_pend = 0; m_last = DEF; m_shd = DEF;
      end else if (m_rem == 0) begin
        if (l || m_pend || au) begin
          exp_q.push_back(d);
          m_shd = d; m_rem = FRAME; m_pend = 0;
        end
      end else begin
        if (l || au) m_pend = 1;
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1; m_last = m_shd;
        end
      end
    end
  end

  // Monitor: per-cycle status plus serial capture, sampled on negedge.
  initial begin
    bit           p_csn = 1, p_sclk = 0, p_sd = 0;
    int           t = 0, nb = 0;
    logic [W-1:0] word = '0;
    forever begin
      @(negedge clk);
      check("busy", busy, m_rem != 0);
      check("cs_n", cs_n, m_rem == 0);
      check("done", done, m_done);
      check("last", last, m_last);
      if (m_rem == 0) begin
        check("sclk_idle", sclk, 0);
        check("sdata_idle", sdata, 0);
      end
      if (p_sclk && sclk) check("sdata_stable", sdata, p_sd);
      if (p_csn && !cs_n) begin
        t = 0; nb = 0; word = '0;
      end else begin
        t++;
      end
      if (!cs_n && sclk && !p_sclk) begin
        check("rise_time", t, 2 * H + 2 * H * nb);
        word = {word[W-2:0], sdata};
        nb++;
      end
      if (done) begin
        check("frame_len", t, FRAME);
        check("nbits", nb, W);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL data got=%0h exp=<none>", word);
        end else begin
          check("data", word, exp_q.pop_front());
        end
      end
      p_csn = cs_n; p_sclk = sclk; p_sd = sdata;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    load = 1'b1; tick(); load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; din = '0;
    tick(3);
    check("rst_csn", cs_n, 1);
    check("rst_last", last, DEF);
    rst_n = 1'b1;
    tick(2);
    // single frame
    din = 16'hA5C3; pulse();
    tick(80);
    check("last_a5c3", last, 16'hA5C3);
    // DIN change mid-frame
    pulse(); tick(19); din = 16'h1234;
    tick(100);
    // three LOADs during a frame
    din = 16'h5A5A; pulse();
    tick(9); pulse(); tick(9); pulse(); tick(9); pulse();
    din = 16'h00FF;
    tick(160);
    // reset mid-frame
    din = 16'hC001; pulse(); tick(28);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("abort_csn", cs_n, 1);
    check("abort_busy", busy, 0);
    check("abort_last", last, DEF);
    tick(3); pulse(); tick(80);
    // LOAD held high
    load = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i % 17 == 0) din = W'($urandom);
      tick();
    end
    load = 1'b0;
    tick(80);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 699) != 0);
      if ($urandom_range(0, 7) == 0) din = W'($urandom);
      tick();
    end
    load = 1'b0; rst_n = 1'b1;
    tick(FRAME * 2 + 10);
    check("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
